// File: rtl/qspi_rx_loader.sv
// qspi_rx_loader
//   Quad-SPI slave receiver feeding the program/data RAM loader port.
//   The QSPI pins are synchronised into clk_i, nibbles are assembled into a
//   start address followed by DATA_WIDTH-bit words, and each completed word
//   produces a single-cycle write strobe with an auto-incrementing address.
//
// Ports
//   clk_i        system clock (must run at least 4x the QSPI clock)
//   reset_i      synchronous active-high reset
//   qspi_cs_n_i  chip select, async, active low
//   qspi_sck_i   QSPI clock, async, data sampled on its rising edge
//   qspi_io_i    data nibble, async
//   wr_en_o      one-cycle write strobe
//   addr_o       write address, valid with wr_en_o
//   data_o       write data, valid with wr_en_o
//   busy_o       frame in progress (address or data phase)
//   frame_done_o one-cycle pulse at a clean end of frame
//   frame_err_o  sticky: last frame ended on a partial field
module qspi_rx_loader #(
  parameter int ADDR_WIDTH  = 13,
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  qspi_cs_n_i,
  input  logic                  qspi_sck_i,
  input  logic [3:0]            qspi_io_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  frame_err_o
);

  localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
  localparam int ADDR_NIBS  = 2 * ADDR_BYTES;
  localparam int DATA_NIBS  = DATA_WIDTH / 4;
  localparam int NIB_MAX    = (ADDR_NIBS > DATA_NIBS) ? ADDR_NIBS : DATA_NIBS;
  localparam int CNT_W      = $clog2(NIB_MAX + 1);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_NIBS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_NIBS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  // Synchronisers are deliberately not reset: after a reset the FSM must see
  // the true pin level so that a frame already in flight is ignored.
  logic [SYNC_STAGES-1:0]      cs_sync;
  logic [SYNC_STAGES:0]        sck_sync;
  logic [SYNC_STAGES-1:0][3:0] io_sync;

  always_ff @(posedge clk_i) begin
    cs_sync  <= {cs_sync[SYNC_STAGES-2:0], qspi_cs_n_i};
    sck_sync <= {sck_sync[SYNC_STAGES-1:0], qspi_sck_i};
    io_sync  <= {io_sync[SYNC_STAGES-2:0], qspi_io_i};
  end

  logic       cs_s;
  logic       sck_rise;
  logic [3:0] io_s;

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_rise = sck_sync[SYNC_STAGES-1] & ~sck_sync[SYNC_STAGES];
  assign io_s     = io_sync[SYNC_STAGES-1];

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rearm_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [DATA_WIDTH-1:0] word_next;

  logic frame_start;
  logic addr_shift_en;
  logic addr_load;
  logic word_shift_en;
  logic word_write;
  logic end_clean;
  logic end_partial;

  // Shift registers hold only the bits that survive into the final field:
  // the incoming nibble completes the value, older bits fall off the top.
  // The address field may be wider on the wire than ADDR_WIDTH; its excess
  // high bits are dropped here.
  if (ADDR_WIDTH > 4) begin : g_addr_sr
    logic [ADDR_WIDTH-5:0] addr_sr_q;
    always_ff @(posedge clk_i) begin
      if (addr_shift_en) addr_sr_q <= addr_next[ADDR_WIDTH-5:0];
    end
    assign addr_next = {addr_sr_q, io_s};
  end else begin : g_addr_nib
    assign addr_next = io_s[ADDR_WIDTH-1:0];
  end

  if (DATA_WIDTH > 4) begin : g_word_sr
    logic [DATA_WIDTH-5:0] word_sr_q;
    always_ff @(posedge clk_i) begin
      if (word_shift_en) word_sr_q <= word_next[DATA_WIDTH-5:0];
    end
    assign word_next = {word_sr_q, io_s};
  end else begin : g_word_nib
    assign word_next = io_s;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A cs_n rise outranks an SCK rise seen in the same cycle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    frame_start   = 1'b0;
    addr_shift_en = 1'b0;
    addr_load     = 1'b0;
    word_shift_en = 1'b0;
    word_write    = 1'b0;
    end_clean     = 1'b0;
    end_partial   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rearm_q && !cs_s) begin
          state_d     = S_ADDR;
          cnt_d       = '0;
          frame_start = 1'b1;
        end
      end
      S_ADDR: begin
        if (cs_s) begin
          state_d     = S_DONE;
          end_partial = 1'b1;
        end else if (sck_rise) begin
          addr_shift_en = 1'b1;
          if (cnt_q == ADDR_LAST) begin
            addr_load = 1'b1;
            cnt_d     = '0;
            state_d   = S_DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DATA: begin
        if (cs_s) begin
          state_d     = S_DONE;
          end_clean   = (cnt_q == '0);
          end_partial = (cnt_q != '0);
        end else if (sck_rise) begin
          word_shift_en = 1'b1;
          if (cnt_q == DATA_LAST) begin
            word_write = 1'b1;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rearm_q      <= 1'b0;
      addr_q       <= '0;
      wr_en_o      <= 1'b0;
      addr_o       <= '0;
      data_o       <= '0;
      frame_done_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      rearm_q      <= rearm_q | cs_s;
      wr_en_o      <= word_write;
      frame_done_o <= end_clean;
      if (word_write) begin
        data_o <= word_next;
        addr_o <= addr_q;
      end
      // Increment the cycle after the strobe so addr_o carries the old value.
      if (addr_load) addr_q <= addr_next;
      else if (wr_en_o) addr_q <= addr_q + ADDR_WIDTH'(1);
      if (frame_start) frame_err_o <= 1'b0;
      else if (end_partial) frame_err_o <= 1'b1;
    end
  end

  assign busy_o = (state_q == S_ADDR) || (state_q == S_DATA);

endmodule

// File: tb/tb_qspi_rx_loader.sv
// Self-checking bench for qspi_rx_loader: two instances (default widths and a
// 32-bit data / 10-bit address variant) each with their own QSPI pins.
// Expected writes and end-of-frame outcomes are queued by the stimulus and
// consumed by a monitor that watches the DUT outputs.
module tb_qspi_rx_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_i;

  logic        cs_a, sck_a;
  logic [3:0]  io_a;
  logic        wr_a, busy_a, done_a, err_a;
  logic [12:0] addr_a;
  logic [7:0]  data_a;

  logic        cs_b, sck_b;
  logic [3:0]  io_b;
  logic        wr_b, busy_b, done_b, err_b;
  logic [9:0]  addr_b;
  logic [31:0] data_b;

  qspi_rx_loader dut_a (
    .clk_i(clk), .reset_i(reset_i),
    .qspi_cs_n_i(cs_a), .qspi_sck_i(sck_a), .qspi_io_i(io_a),
    .wr_en_o(wr_a), .addr_o(addr_a), .data_o(data_a),
    .busy_o(busy_a), .frame_done_o(done_a), .frame_err_o(err_a)
  );

  qspi_rx_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut_b (
    .clk_i(clk), .reset_i(reset_i),
    .qspi_cs_n_i(cs_b), .qspi_sck_i(sck_b), .qspi_io_i(io_b),
    .wr_en_o(wr_b), .addr_o(addr_b), .data_o(data_b),
    .busy_o(busy_b), .frame_done_o(done_b), .frame_err_o(err_b)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_a[$], exp_b[$];
  bit          ev_a[$], ev_b[$];
  logic [31:0] words_q[$];
  int          tests_run = 0;
  int          failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon_write(input bit sel, input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    if (sel ? (exp_b.size() == 0) : (exp_a.size() == 0)) begin
      tests_run++;
      failed++;
      $display("FAIL %s_unexpected_write: got addr %0h data %0h expected no write",
               sel ? "b" : "a", a, d);
    end else begin
      e = sel ? exp_b.pop_front() : exp_a.pop_front();
      check(sel ? "b_write_addr" : "a_write_addr", a, e.addr);
      check(sel ? "b_write_data" : "a_write_data", d, e.data);
    end
  endtask

  task automatic mon_event(input bit sel, input bit clean);
    bit e;
    if (sel ? (ev_b.size() == 0) : (ev_a.size() == 0)) begin
      tests_run++;
      failed++;
      $display("FAIL %s_unexpected_frame_end: got clean=%0d expected no frame end",
               sel ? "b" : "a", clean);
    end else begin
      e = sel ? ev_b.pop_front() : ev_a.pop_front();
      check(sel ? "b_frame_end_clean" : "a_frame_end_clean", 32'(clean), 32'(e));
    end
  endtask

  logic wr_a_p = 1'b0, done_a_p = 1'b0, err_a_p = 1'b0;
  logic wr_b_p = 1'b0, done_b_p = 1'b0, err_b_p = 1'b0;

  always @(negedge clk) begin
    if (wr_a) begin
      check("a_strobe_single_cycle", 32'(wr_a_p), 32'd0);
      mon_write(1'b0, 32'(addr_a), 32'(data_a));
    end
    if (done_a) begin
      check("a_done_single_cycle", 32'(done_a_p), 32'd0);
      mon_event(1'b0, 1'b1);
    end
    if (err_a && !err_a_p) mon_event(1'b0, 1'b0);
    if (wr_b) begin
      check("b_strobe_single_cycle", 32'(wr_b_p), 32'd0);
      mon_write(1'b1, 32'(addr_b), data_b);
    end
    if (done_b) begin
      check("b_done_single_cycle", 32'(done_b_p), 32'd0);
      mon_event(1'b1, 1'b1);
    end
    if (err_b && !err_b_p) mon_event(1'b1, 1'b0);
    wr_a_p = wr_a; done_a_p = done_a; err_a_p = err_a;
    wr_b_p = wr_b; done_b_p = done_b; err_b_p = err_b;
  end

  // One nibble: present data, hold 4 clocks, raise SCK for 4 clocks.
  task automatic nib(input bit sel, input logic [3:0] n);
    if (sel) io_b = n; else io_a = n;
    repeat (4) @(negedge clk);
    if (sel) sck_b = 1'b1; else sck_a = 1'b1;
    repeat (4) @(negedge clk);
    if (sel) sck_b = 1'b0; else sck_a = 1'b0;
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w);
    int nn;
    nn = sel ? 8 : 2;
    for (int j = 0; j < nn; j++) nib(sel, w[4*(nn-1-j) +: 4]);
  endtask

  // Full frame: addr_nibs address nibbles (4 = complete), then words_q (only
  // when the address is complete), then extra stray nibbles.
  task automatic run_frame(input bit sel, input logic [15:0] wire_addr,
                           input int addr_nibs, input int extra);
    logic [31:0] mask;
    wr_t         e;
    mask = sel ? 32'h3FF : 32'h1FFF;
    if (sel) cs_b = 1'b0; else cs_a = 1'b0;
    repeat (6) @(negedge clk);
    check(sel ? "b_busy_in_frame" : "a_busy_in_frame", 32'(sel ? busy_b : busy_a), 32'd1);
    check(sel ? "b_err_cleared_at_start" : "a_err_cleared_at_start",
          32'(sel ? err_b : err_a), 32'd0);
    for (int i = 0; i < addr_nibs; i++) nib(sel, wire_addr[15-4*i -: 4]);
    if (addr_nibs == 4) begin
      for (int k = 0; k < words_q.size(); k++) begin
        e.addr = (32'(wire_addr) + 32'(k)) & mask;
        e.data = words_q[k];
        if (sel) exp_b.push_back(e); else exp_a.push_back(e);
        send_word(sel, words_q[k]);
      end
    end
    for (int x = 0; x < extra; x++) nib(sel, 4'($urandom));
    if (sel) ev_b.push_back(addr_nibs == 4 && extra == 0);
    else     ev_a.push_back(addr_nibs == 4 && extra == 0);
    if (sel) cs_b = 1'b1; else cs_a = 1'b1;
    repeat (10) @(negedge clk);
    check(sel ? "b_idle_after_frame" : "a_idle_after_frame", 32'(sel ? busy_b : busy_a), 32'd0);
    words_q.delete();
  endtask

  task automatic random_frame(input bit sel);
    int r, an, ex, nw;
    r  = int'($urandom_range(0, 7));
    nw = int'($urandom_range(0, 4));
    an = 4;
    ex = 0;
    if (r == 0) an = int'($urandom_range(0, 3));
    else if (r == 1) ex = sel ? int'($urandom_range(1, 7)) : 1;
    for (int k = 0; k < nw; k++) words_q.push_back(sel ? $urandom : 32'($urandom_range(0, 255)));
    run_frame(sel, 16'($urandom), an, ex);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    wr_t e;
    reset_i = 1'b1;
    cs_a = 1'b1; sck_a = 1'b0; io_a = '0;
    cs_b = 1'b1; sck_b = 1'b0; io_b = '0;
    repeat (3) begin
      @(negedge clk);
      sck_a = 1'($urandom); io_a = 4'($urandom);
      sck_b = 1'($urandom); io_b = 4'($urandom);
    end
    @(negedge clk);
    check("a_reset_wr_en", 32'(wr_a), 0);
    check("a_reset_addr", 32'(addr_a), 0);
    check("a_reset_data", 32'(data_a), 0);
    check("a_reset_busy", 32'(busy_a), 0);
    check("a_reset_done", 32'(done_a), 0);
    check("a_reset_err", 32'(err_a), 0);
    check("b_reset_wr_en", 32'(wr_b), 0);
    check("b_reset_addr", 32'(addr_b), 0);
    check("b_reset_data", data_b, 0);
    check("b_reset_busy", 32'(busy_b), 0);
    sck_a = 1'b0; sck_b = 1'b0;
    reset_i = 1'b0;
    repeat (6) @(negedge clk);
    check("a_idle_after_reset", 32'(busy_a), 0);

    // Basic load
    words_q.push_back(32'hA5); words_q.push_back(32'h3C);
    run_frame(1'b0, 16'h0020, 4, 0);
    // Address wrap
    words_q.push_back(32'h11); words_q.push_back(32'h22);
    run_frame(1'b0, 16'h1FFF, 4, 0);
    // Partial abort then a clean frame that must clear the error flag
    words_q.push_back(32'hA5);
    run_frame(1'b0, 16'h0100, 4, 1);
    check("a_err_sticky", 32'(err_a), 1);
    run_frame(1'b0, 16'h0000, 4, 0);
    // Aborted address field
    run_frame(1'b0, 16'h1234, 2, 0);

    // Reset mid-frame: the remainder of the frame must be ignored
    cs_a = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 4; i++) nib(1'b0, 4'(i == 2 ? 4 : 0));
    for (int k = 0; k < 3; k++) begin
      e.addr = 32'h40 + 32'(k);
      e.data = 32'h61 + 32'(k);
      exp_a.push_back(e);
      send_word(1'b0, e.data);
    end
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    check("a_mid_reset_addr", 32'(addr_a), 0);
    check("a_mid_reset_data", 32'(data_a), 0);
    for (int k = 0; k < 4; k++) send_word(1'b0, $urandom);
    check("a_ignored_frame_busy", 32'(busy_a), 0);
    cs_a = 1'b1;
    repeat (10) @(negedge clk);
    words_q.push_back(32'h5A); words_q.push_back(32'hC3);
    run_frame(1'b0, 16'h0ABC, 4, 0);

    for (int n = 0; n < 16; n++) random_frame(1'b0);

    // Wide instance
    words_q.push_back(32'hDEADBEEF);
    run_frame(1'b1, 16'h0004, 4, 0);
    words_q.push_back(32'h01234567); words_q.push_back(32'h89ABCDEF);
    run_frame(1'b1, 16'hFFFF, 4, 0);
    for (int n = 0; n < 5; n++) random_frame(1'b1);

    repeat (20) @(negedge clk);
    check("a_writes_outstanding", 32'(exp_a.size()), 0);
    check("b_writes_outstanding", 32'(exp_b.size()), 0);
    check("a_frame_ends_outstanding", 32'(ev_a.size()), 0);
    check("b_frame_ends_outstanding", 32'(ev_b.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/qspi_rx_loader.md
Name: qspi_rx_loader

Overview:
- Quad-SPI slave receiver that replaces the combinational data mux previously used for STM32-to-FPGA transfers.
- Synchronises the external QSPI pins into the system clock domain and assembles nibbles into a start address plus a stream of DATA_WIDTH-bit words.
- Emits single-cycle memory write strobes with an auto-incrementing address.
- Sits between the STM32 QSPI pins and the FPGA program/data RAM loader port.

Parameters:
- ADDR_WIDTH, 13, width of addr_o; the address field on the wire is ADDR_BYTES = ceil(ADDR_WIDTH/8) bytes.
- DATA_WIDTH, 8, word width; must be a multiple of 4 and at least 4.
- SYNC_STAGES, 2, flip-flop stages on each QSPI input; must be at least 2.

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  synchronous, active-high reset.
- qspi_cs_n_i  input  1  chip select, asynchronous, active low.
- qspi_sck_i  input  1  QSPI clock, asynchronous; data is sampled on its rising edge.
- qspi_io_i  input  4  data nibble, asynchronous.
- wr_en_o  output  1  one-cycle write strobe.
- addr_o  output  ADDR_WIDTH  write address, valid while wr_en_o is high.
- data_o  output  DATA_WIDTH  write data, valid while wr_en_o is high.
- busy_o  output  1  high while a frame is active (state ADDR or DATA).
- frame_done_o  output  1  one-cycle pulse at a clean end of frame.
- frame_err_o  output  1  sticky flag: last frame ended with a partial field; cleared at the start of the next frame.

Behaviour:
- Synchronisation: cs_n, sck and io each pass through SYNC_STAGES flops. An SCK rise is detected when the previous synced sck is 0 and the current synced sck is 1 (rise cycle E). io is sampled in the same cycle from its synced copy. Requirement: f_clk >= 4 x f_sck.
- Reset: all state returns to IDLE.
  - wr_en_o=0, addr_o=0, data_o=0, busy_o=0, frame_done_o=0, frame_err_o=0.
  - The rearm flag is cleared, so no frame starts until synced cs_n has been observed high for at least one cycle. A reset mid-frame therefore ignores the rest of that frame.
- Frame format: while cs_n is low, the transfer is 2*ADDR_BYTES address nibbles followed by any number of words of DATA_WIDTH/4 nibbles each. All fields are MSB nibble first.
  - The address shift register is ADDR_BYTES*8 bits wide; only the low ADDR_WIDTH bits are kept.
- States:
  - IDLE: when rearmed and synced cs_n falls to 0, go to ADDR, clear the nibble counter, clear frame_err_o.
  - ADDR: each SCK rise shifts in one nibble. On the 2*ADDR_BYTES-th nibble, load the address register and go to DATA.
  - DATA: each SCK rise shifts a nibble into the word register. On the last nibble of a word:
    - cycle E+1: wr_en_o=1, data_o=assembled word, addr_o=current address;
    - cycle E+2: wr_en_o=0 and the address register has incremented by 1.
  - DONE: a one-cycle state that pulses frame_done_o, or sets frame_err_o, then returns to IDLE.
- End of frame: synced cs_n rises in any non-IDLE state → DONE.
  - Clean end (DATA state with nibble counter 0): frame_done_o=1 for one cycle, frame_err_o unchanged (0).
  - Partial end (ADDR state, or DATA with counter not 0): partial data is discarded, no write occurs, frame_done_o=0, frame_err_o=1.
  - An address-only frame (cs_n rises right after the address completes) counts as a clean end with zero writes.
- Address wrap: the increment is modulo 2^ADDR_WIDTH; all-ones wraps to 0 with no flag.
- Simultaneous events: an SCK rise detected in the same cycle that synced cs_n rises is ignored. The cs_n rise takes priority.
- addr_o and data_o hold their last written values between strobes; they change only when wr_en_o is asserted or on reset.
- wr_en_o never stays high for two consecutive cycles; this follows from the SCK rate limit.

Test Plan:
- Reset then idle: hold reset_i 3 cycles with random pins and cs_n high → all outputs 0, busy_o=0.
- Basic load (defaults): address nibbles 0,0,2,0 (addr 0x0020), then bytes 0xA5, 0x3C → two wr_en_o pulses.
  - Pulse 1: (0x0020, 0xA5); pulse 2: (0x0021, 0x3C).
  - Then frame_done_o=1 once and busy_o falls.
- Wrap: address 0x1FFF, data 0x11, 0x22 → writes (0x1FFF, 0x11), then (0x0000, 0x22).
- Partial abort: address 0x0100, data nibbles A,5,C then cs_n high → one write (0x0100, 0xA5), no second write, frame_err_o=1, frame_done_o=0.
  - The next frame clears frame_err_o at its start.
- Reset mid-frame: assert reset_i after 3 data bytes with cs_n still low, keep clocking SCK → no writes until cs_n goes high and then low again; the new frame loads correctly.
- Width parameter: DATA_WIDTH=32, ADDR_WIDTH=10, address nibbles 0,0,0,4 (addr 0x004), data 0xDEADBEEF → a single write (0x004, 0xDEADBEEF), 8 SCK edges after the address.
